// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_MID_BIT    = UART_OVERSAMPLE / 2 - 1;
    localparam int UART_CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Received-word bundle: the receiver drives it, the consumer reads it.
interface uart_receiver_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_perror;
    logic                 rx_ferror;

    modport master (output rx_data, rx_valid, rx_perror, rx_ferror);
    modport slave  (input  rx_data, rx_valid, rx_perror, rx_ferror);

endinterface

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for the serial line; resets to the idle-high level.
module rx_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Oversampled UART receiver: start, DATA_BITS data (LSB first), even parity, one stop bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_enable,
    input  logic            rx_en,
    input  logic            rxd,
    uart_receiver_if.master rx_if
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 valid_q, valid_d;
    logic                 rxd_s;
    logic                 par_bad;

    rx_synchronizer u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    assign par_bad = ^{shift_q, par_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;

        if (!rx_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else if (sample_enable) begin
            // off-compare ticks only advance the counter (mod 2**CNT_W)
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rxd_s) state_d = START;
                end
                START: begin
                    if (cnt_q == MID_CNT) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rxd_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) state_d = PARITY;
                    end
                end
                PARITY: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        par_d   = rxd_s;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        data_d  = shift_q;
                        perr_d  = par_bad;
                        ferr_d  = ~rxd_s;
                        valid_d = ~par_bad & rxd_s;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.rx_perror = perr_q;
    assign rx_if.rx_ferror = ferr_q;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, number of sample_enable ticks per bit period.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 sample_enable  input  1  one-clk oversample tick from the baud sample generator, OVERSAMPLE per bit.
REQ-006 rx_en  input  1  receiver enable; low forces IDLE.
REQ-007 rxd  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  DATA_BITS  last received data word.
REQ-009 rx_valid  output  1  one-clk pulse: frame received with good parity and stop bit.
REQ-010 rx_perror  output  1  parity error flag of last completed frame.
REQ-011 rx_ferror  output  1  framing (stop bit) error flag of last completed frame.

Function
REQ-012 Frame format SHALL be: start (0), DATA_BITS data LSB first, even parity bit, one stop (1).
REQ-013 rxd SHALL pass a 2-flop synchronizer; all decisions use synchronized value rxd_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a 4-bit tick counter advances only on sample_enable.
REQ-015 IDLE: on a sample_enable tick with rxd_s==0 and rx_en==1, go START, counter=0.
REQ-016 START: each tick increments counter; on tick where counter==OVERSAMPLE/2-1 (7), rxd_s==0 -> DATA, counter=0; rxd_s==1 -> IDLE (glitch rejected, no outputs change).
REQ-017 DATA: on tick where counter==OVERSAMPLE-1 (15), shift rxd_s into data shift register (LSB first), counter wraps to 0; after DATA_BITS samples go PARITY.
REQ-018 PARITY: on tick with counter==15, capture parity bit; go STOP, counter=0.
REQ-019 STOP: on tick with counter==15, sample stop bit; go IDLE.
REQ-020 Completion: clk cycle after stop-bit sample, rx_data, rx_perror, rx_ferror SHALL update together; rx_perror=1 iff XOR(data,parity)!=0; rx_ferror=1 iff stop bit==0.
REQ-021 rx_valid SHALL pulse exactly one clk in the completion cycle iff rx_perror==0 and rx_ferror==0.
REQ-022 rx_data SHALL update on every completed frame, including errored ones; flags hold until next completion.
REQ-023 Ticks arriving outside counter compare points SHALL only increment counter; clk cycles without sample_enable SHALL hold all state.
REQ-024 rx_en deasserted in any state SHALL return FSM to IDLE next clk, counter=0, discard partial frame; outputs hold, no rx_valid.
REQ-025 A new start bit SHALL be accepted on the first tick after returning to IDLE (back-to-back frames, no gap required).
REQ-026 Counter arithmetic SHALL be modulo 16; no overflow path other than the compare-point wraps.

Reset
REQ-027 reset SHALL force: state IDLE, counter 0, shift register 0, synchronizer flops 1, rx_data 0, rx_valid 0, rx_perror 0, rx_ferror 0.
REQ-028 reset mid-frame SHALL abort immediately; first frame after release starts at a fresh start-bit edge.

Structure
REQ-029 Shared package uart_pkg SHALL hold state encodings, OVERSAMPLE, DATA_BITS, mid-bit compare constant.
REQ-030 Synchronizer SHALL be a sub-module rx_synchronizer (2 flops, reset value 1); the sample generator stays external, feeding sample_enable.

Verification
REQ-031 Frame 0xA5, parity 0, stop 1, 16 ticks/bit -> one rx_valid pulse, rx_data=0xA5, both flags 0.
REQ-032 Frame 0x3C, parity bit 1 (wrong) -> rx_data=0x3C, rx_perror=1, rx_valid never high.
REQ-033 Frame 0xFF, parity 0, stop 0 -> rx_ferror=1, rx_valid never high; next good frame 0x01 parity 1 clears both flags, rx_valid pulses.
REQ-034 rxd low for 4 ticks then high -> FSM returns to IDLE, no output change.
REQ-035 rx_en dropped during data bit 3 of 0x55, reasserted, then frame 0x0F parity 0 sent -> single rx_valid, rx_data=0x0F.
REQ-036 Two back-to-back frames 0x12, 0x34 with zero idle gap, then reset asserted mid third frame -> two rx_valid pulses with correct data, then all outputs 0.
